fft_reorder_buffer: RTL and testbench
=====================================

Name: fft_reorder_buffer

Overview:
- Receiving end of the FFT output stream. Accepts 16-point FFT results in bit-reversed bin order over the push/stall interface.
- Buffers each complete frame in a ping-pong pair of register banks.
- Re-emits each frame in natural bin order (bin 0..15) on an identical push/stall interface for downstream consumers.
- Sits directly after fft_top.

Parameters:
- N_LOG2, 4, log2 of frame length; frame length N = 2**N_LOG2 = 16.
- WIDTH, 16, bit width of each signed real/imag component.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_push  in  1  upstream sample valid.
- in_real  in  WIDTH  signed real part, bit-reversed order.
- in_imag  in  WIDTH  signed imaginary part.
- in_stall  out  1  upstream must hold its sample; no transfer this cycle.
- out_push  out  1  output sample valid.
- out_real  out  WIDTH  signed real part, natural order.
- out_imag  out  WIDTH  signed imaginary part.
- out_stall  in  1  downstream cannot accept.

Behaviour:
- Transfer rule, both sides: a sample moves on a rising edge when push=1 and stall=0. While stalled, the producer holds push and data stable.
- Storage: two banks × N entries × 2·WIDTH, held in flops.
- Per-bank full flag, wr_bank pointer and wr_cnt (N_LOG2 bits), rd_bank pointer and rd_cnt.
- Write side:
  - On input transfer, store {in_real, in_imag} at bank[wr_bank][bitrev(wr_cnt)], where bitrev mirrors the N_LOG2 bits; then wr_cnt++.
  - When wr_cnt = N-1 on a transfer: wr_cnt→0, full[wr_bank]→1, wr_bank toggles.
- in_stall = full[wr_bank]. It is driven from registers only, with no combinational path from out_stall.
- Read side:
  - out_push = full[rd_bank].
  - out_real/out_imag = bank[rd_bank][rd_cnt]. These come combinationally from the storage flops and are stable while stalled.
  - On output transfer, rd_cnt++. When rd_cnt = N-1: rd_cnt→0, full[rd_bank]→0, rd_bank toggles.
- Latency: a frame's last input transfer at edge E sets the full flag. out_push is high after E, so the first output transfer can occur at edge E+1. There is no output before the frame is complete.
- Throughput: one sample/cycle on each side. Back-to-back frames run with no bubbles while the downstream does not stall.
- Simultaneous events:
  - The final write of bank A and the final read of bank B on the same edge are independent; both flags update.
  - A final read that frees the bank wr_bank points to clears in_stall in the next cycle only (registered).
- Both banks full: in_stall=1 until one full frame drains.
- Reset (async, any time, including mid-frame):
  - Counters → 0, pointers → bank 0, full flags → 0.
  - out_push=0, in_stall=0.
  - Partial or undelivered frames are discarded.
  - Storage contents need no reset; outputs read 0-gated only via out_push.
- Arithmetic: pure data movement, no width change, signed values passed bit-exact.

Optional Feature:
- Macro FFT_REORDER_LAST_EN.
- When defined, adds output port out_last (1 bit), equal to out_push & (rd_cnt = N-1); it marks bin N-1 of every frame. Reset value 0.
- When undefined, the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fft_pkg:
  - FFT_N_LOG2 = 4, FFT_N = 16, FFT_WIDTH = 16.
  - Typedef cplx_t {signed [WIDTH-1:0] re, im}.
  - bitrev function.
- One natural sub-module: fft_reorder_bank, a single N-entry store with write-address/data/enable, combinational read address/data, and its own full flag set/clear. Instantiate twice.

Test Plan:
- Bit-reversed ramp: input arrival j carries in_real = bitrev(j)·100, in_imag = -bitrev(j), out_stall=0 → outputs real 0,100,…,1500, imag 0,-1,…,-15; first out_push exactly 1 cycle after the 16th input transfer.
- Back-to-back: 3 frames pushed continuously (frame f adds f·2000) → 48 natural-order outputs with no out_push gaps after the first; in_stall never asserted.
- Backpressure: out_stall=1 held throughout, push 2 frames → in_stall=1 after the 32nd transfer. Then release out_stall → frame 0 drains. in_stall drops the cycle after frame 0's last read, and out_real stays stable while stalled.
- Random out_stall (50%) and random in_push gaps over 10 random frames → scoreboard matches bitrev-reordered input exactly, with no duplicates and no drops.
- Reset mid-frame: push 7 samples, pulse reset low for 1 cycle, push a full ramp frame → output equals the ramp only; out_push=0 and in_stall=0 during reset.
- FFT_REORDER_LAST_EN defined: out_last=1 only on the transfer of bin 15 for each of 2 frames, and 0 otherwise.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, complex sample type, bit-reversal helper.
package fft_pkg;

  localparam int unsigned FFT_N_LOG2 = 4;
  localparam int unsigned FFT_N      = 1 << FFT_N_LOG2;
  localparam int unsigned FFT_WIDTH  = 16;

  typedef struct packed {
    logic signed [FFT_WIDTH-1:0] re;
    logic signed [FFT_WIDTH-1:0] im;
  } cplx_t;

  // Mirror the low n bits of x; bits at and above n are returned as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int unsigned n);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) r[n - 1 - i] = x[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame store: flop array with synchronous write, combinational read and a full flag.
module fft_reorder_bank #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          set_full,
  input  logic          clr_full,
  output logic          full
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Sample storage; contents are qualified by the full flag so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

  // Full flag: set by the final write of a frame, cleared by its final read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        full <= 1'b0;
    else if (set_full) full <= 1'b1;
    else if (clr_full) full <= 1'b0;
  end

endmodule

// File: rtl/fft_reorder_buffer.sv
// Ping-pong reorder buffer: bit-reversed FFT frames in, natural-order frames out.
// Optional macro FFT_REORDER_LAST_EN adds out_last marking bin N-1 of each frame.
module fft_reorder_buffer
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2 = FFT_N_LOG2,
  parameter int unsigned WIDTH  = FFT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_push,
  input  logic signed [WIDTH-1:0] in_real,
  input  logic signed [WIDTH-1:0] in_imag,
  output logic                    in_stall,
  output logic                    out_push,
  output logic signed [WIDTH-1:0] out_real,
  output logic signed [WIDTH-1:0] out_imag,
`ifdef FFT_REORDER_LAST_EN
  output logic                    out_last,
`endif
  input  logic                    out_stall
);

  localparam int unsigned N  = 1 << N_LOG2;
  localparam int unsigned DW = 2 * WIDTH;
  localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N - 1);

  logic              wr_bank;
  logic              rd_bank;
  logic [N_LOG2-1:0] wr_cnt;
  logic [N_LOG2-1:0] rd_cnt;
  logic [N_LOG2-1:0] wr_addr;
  logic [1:0]        full;
  logic [1:0]        wr_en;
  logic [1:0]        set_full;
  logic [1:0]        clr_full;
  logic [DW-1:0]     rd_data [2];
  logic              in_xfer;
  logic              out_xfer;

  assign in_stall = full[wr_bank];
  assign out_push = full[rd_bank];
  assign in_xfer  = in_push & ~in_stall;
  assign out_xfer = out_push & ~out_stall;
  assign wr_addr  = N_LOG2'(bitrev(32'(wr_cnt), N_LOG2));

  assign {out_real, out_imag} = rd_data[rd_bank];

`ifdef FFT_REORDER_LAST_EN
  assign out_last = out_push & (rd_cnt == LAST);
`endif

  // Steer write enables and flag updates to the bank each pointer selects.
  always_comb begin
    wr_en    = '0;
    set_full = '0;
    clr_full = '0;
    wr_en[wr_bank]    = in_xfer;
    set_full[wr_bank] = in_xfer & (wr_cnt == LAST);
    clr_full[rd_bank] = out_xfer & (rd_cnt == LAST);
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(
      .AW (N_LOG2),
      .DW (DW)
    ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en[b]),
      .wr_addr  (wr_addr),
      .wr_data  ({in_real, in_imag}),
      .rd_addr  (rd_cnt),
      .rd_data  (rd_data[b]),
      .set_full (set_full[b]),
      .clr_full (clr_full[b]),
      .full     (full[b])
    );
  end

  // Write-side counter and bank pointer; the counter wraps naturally at N.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (in_xfer) begin
      wr_cnt <= wr_cnt + N_LOG2'(1);
      if (wr_cnt == LAST) wr_bank <= ~wr_bank;
    end
  end

  // Read-side counter and bank pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (out_xfer) begin
      rd_cnt <= rd_cnt + N_LOG2'(1);
      if (rd_cnt == LAST) rd_bank <= ~rd_bank;
    end
  end

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Scoreboard bench for fft_reorder_buffer; honours FFT_REORDER_LAST_EN when defined.
module tb_fft_reorder_buffer;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_push;
  logic signed [15:0] in_real;
  logic signed [15:0] in_imag;
  logic               in_stall;
  logic               out_push;
  logic signed [15:0] out_real;
  logic signed [15:0] out_imag;
  logic               out_stall;
`ifdef FFT_REORDER_LAST_EN
  logic               out_last;
`endif

  int checks = 0;
  int errors = 0;
  int stall_waits = 0;
  int stall_mode = 0;

  // reference model state: arrival-order frame, expected natural-order outputs
  logic [31:0] exp_q [$];
  logic [15:0] fr_re [16];
  logic [15:0] fr_im [16];
  int in_cnt = 0;
  int out_idx = 0;

  always #5 clk = ~clk;

  fft_reorder_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .in_push   (in_push),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .in_stall  (in_stall),
    .out_push  (out_push),
    .out_real  (out_real),
    .out_imag  (out_imag),
`ifdef FFT_REORDER_LAST_EN
    .out_last  (out_last),
`endif
    .out_stall (out_stall)
  );

  function automatic int rev4(input int x);
    return ((x & 1) << 3) | ((x & 2) << 1) | ((x & 4) >> 1) | ((x & 8) >> 3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // A sample arriving j-th in a frame belongs to bin rev4(j); emit bins 0..15.
  task automatic model_in(input logic [15:0] re, input logic [15:0] im);
    fr_re[in_cnt] = re;
    fr_im[in_cnt] = im;
    in_cnt++;
    if (in_cnt == 16) begin
      for (int k = 0; k < 16; k++) exp_q.push_back({fr_re[rev4(k)], fr_im[rev4(k)]});
      in_cnt = 0;
    end
  endtask

  // Drive one sample, hold it while stalled; returns at posedge+1 after its transfer.
  task automatic push_sample(input logic [15:0] re, input logic [15:0] im);
    bit done = 0;
    in_push = 1'b1;
    in_real = re;
    in_imag = im;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      if (!in_stall) begin
        model_in(re, im);
        done = 1;
      end else stall_waits++;
    end
    if (!done) begin
      errors++;
      $display("FAIL push_timeout: in_stall stuck high");
    end
    @(posedge clk);
    #1;
    in_push = 1'b0;
  endtask

  task automatic idle(input int n);
    in_push = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Random backpressure generator, active only in mode 2.
  always @(posedge clk) begin
    #1;
    if (stall_mode == 2) out_stall = 1'($urandom_range(0, 1));
  end

  // Output monitor: scoreboard pop on transfer, hold-stability while stalled.
  logic        held = 1'b0;
  logic [31:0] held_v;
  always @(negedge clk) begin
    if (!reset) begin
      held <= 1'b0;
    end else begin
`ifdef FFT_REORDER_LAST_EN
      check("out_last", 32'(out_last), 32'(out_push && out_idx == 15));
`endif
      if (out_push && held) check("hold_stable", {out_real, out_imag}, held_v);
      if (out_push && out_stall) begin
        held   <= 1'b1;
        held_v <= {out_real, out_imag};
      end else begin
        held <= 1'b0;
      end
      if (out_push && !out_stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", {out_real, out_imag});
        end else begin
          check("out_data", {out_real, out_imag}, exp_q.pop_front());
        end
        out_idx = (out_idx + 1) % 16;
      end
    end
  end

  initial begin
    int gaps;
    bit seen;
    reset = 1'b0;
    in_push = 1'b0;
    in_real = '0;
    in_imag = '0;
    out_stall = 1'b0;
    #12;
    check("rst_out_push", 32'(out_push), 32'd0);
    check("rst_in_stall", 32'(in_stall), 32'd0);
`ifdef FFT_REORDER_LAST_EN
    check("rst_out_last", 32'(out_last), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    // 1: bit-reversed ramp, latency of first output
    for (int j = 0; j < 16; j++) begin
      push_sample(16'(rev4(j) * 100), 16'(-rev4(j)));
      if (j == 14) check("no_early_out", 32'(out_push), 32'd0);
    end
    check("first_out_latency", 32'(out_push), 32'd1);
    check("ramp_bin0_real", 32'(out_real), 32'd0);
    wait_drain("ramp_drain");

    // 2: three back-to-back frames, no bubbles, no input stall
    stall_waits = 0;
    gaps = 0;
    seen = 0;
    fork
      for (int f = 0; f < 3; f++)
        for (int j = 0; j < 16; j++)
          push_sample(16'(f * 2000 + rev4(j) * 100), 16'(-rev4(j) - f));
      begin
        for (int c = 0; c < 200 && !seen; c++) begin
          @(negedge clk);
          if (out_push) seen = 1;
        end
        repeat (47) begin
          @(negedge clk);
          if (!out_push) gaps++;
        end
      end
    join
    check("b2b_seen", 32'(seen), 32'd1);
    check("b2b_gaps", 32'(gaps), 32'd0);
    check("b2b_no_stall", 32'(stall_waits), 32'd0);
    wait_drain("b2b_drain");

    // 3: backpressure, both banks full, release timing
    out_stall = 1'b1;
    for (int j = 0; j < 32; j++) push_sample(16'($urandom), 16'($urandom));
    check("bp_in_stall", 32'(in_stall), 32'd1);
    check("bp_out_push", 32'(out_push), 32'd1);
    idle(4);
    out_stall = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      check("bp_release_stall", 32'(in_stall), (i < 16) ? 32'd1 : 32'd0);
    end
    wait_drain("bp_drain");

    // 4: random gaps and random backpressure over 10 frames
    stall_mode = 2;
    for (int j = 0; j < 160; j++) begin
      idle($urandom_range(0, 2));
      push_sample(16'($urandom), 16'($urandom));
    end
    wait_drain("rand_drain");
    stall_mode = 0;
    @(posedge clk);
    #2;
    out_stall = 1'b0;

    // 5: reset mid-frame discards the partial frame
    for (int j = 0; j < 7; j++) push_sample(16'(16'h7000 + j), 16'(j));
    reset = 1'b0;
    in_cnt = 0;
    exp_q.delete();
    out_idx = 0;
    #1;
    check("mid_rst_out_push", 32'(out_push), 32'd0);
    check("mid_rst_in_stall", 32'(in_stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    for (int j = 0; j < 16; j++) push_sample(16'(rev4(j) * 100), 16'(-rev4(j)));
    wait_drain("post_rst_drain");
    idle(3);
    check("final_no_out", 32'(out_push), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
